// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: word-aligned PC, two-entry {pc, instr} buffer, halt/redirect control.
// Optional FETCH_PERF_CNT_EN adds a fetch_count output counting every buffer push.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] fetch_pc;
    logic [31:0] pc_inc;
    logic [31:0] pc_seq;
    logic [31:0] pc0, pc1, instr0, instr1;
    logic [1:0]  count;
    logic        redirect;
    logic        pop;
    logic        push;

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (halt) state_next = HALT;
            HALT:    if (!halt) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_next;
    end

    // A redirect wins over both push and pop in its cycle; it is ignored while booting.
    assign redirect  = redirect_valid && (state != BOOT);
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready && !redirect;
    assign push      = (state == RUN) && !redirect && ((count != 2'd2) || pop);
    assign pc_inc    = fetch_pc + 32'd4;
    assign pc_seq    = (pc_inc == ADDR_LIMIT) ? RESET_PC : pc_inc;
    assign imem_addr = fetch_pc;
    assign out_pc    = pc0;
    assign out_instr = instr0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~32'h0000_0003;
        end else if (push) begin
            fetch_pc <= pc_seq;
        end
    end

    // Shift-style buffer: entry 0 is always the head, entry 1 the tail when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            pc0    <= 32'd0;
            instr0 <= 32'd0;
            pc1    <= 32'd0;
            instr1 <= 32'd0;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    count <= count + 2'd1;
                    if (count == 2'd0) begin
                        pc0    <= fetch_pc;
                        instr0 <= imem_data;
                    end else begin
                        pc1    <= fetch_pc;
                        instr1 <= imem_data;
                    end
                end
                2'b01: begin
                    count  <= count - 2'd1;
                    pc0    <= pc1;
                    instr0 <= instr1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        pc0    <= fetch_pc;
                        instr0 <= imem_data;
                    end else begin
                        pc0    <= pc1;
                        instr0 <= instr1;
                        pc1    <= fetch_pc;
                        instr1 <= imem_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    fetch_count <= 32'd0;
        else if (push) fetch_count <= fetch_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; memory word[i] = i+1 served combinationally.
// Builds with or without FETCH_PERF_CNT_EN.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr >> 2) + 32'd1;

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges, checks the async clear, then releases #1 after an edge.
    task automatic do_reset(input logic rdy);
        rst_n          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = rdy;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_count", fetch_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        // Streaming with consumer always ready, then wrap at ADDR_LIMIT
        do_reset(1'b1);
        tick;
        chk("boot_valid", {31'd0, out_valid}, 32'd0);
        tick;
        chk("s0_valid", {31'd0, out_valid}, 32'd1);
        chk("s0_pc", out_pc, 32'h0);
        chk("s0_instr", out_instr, 32'd1);
        tick;
        chk("s1_pc", out_pc, 32'h4);
        chk("s1_instr", out_instr, 32'd2);
        tick;
        chk("s2_pc", out_pc, 32'h8);
        chk("s2_instr", out_instr, 32'd3);
        for (int i = 0; i < 40 && out_pc != 32'h3c; i++) tick;
        chk("wrap_pre_pc", out_pc, 32'h3c);
        chk("wrap_pre_instr", out_instr, 32'd16);
        tick;
        chk("wrap_pc", out_pc, 32'h0);
        chk("wrap_instr", out_instr, 32'd1);

        // Backpressure: fill, stall, then drain without gaps (reset mid-operation)
        do_reset(1'b0);
        repeat (5) tick;
        chk("bp_addr", imem_addr, 32'h8);
        chk("bp_head", out_pc, 32'h0);
        out_ready = 1'b1;
        tick;
        chk("bp_d1", out_pc, 32'h4);
        tick;
        chk("bp_d2", out_pc, 32'h8);
        chk("bp_d2_instr", out_instr, 32'd3);
        tick;
        chk("bp_d3", out_pc, 32'hc);

        // Redirect with a full buffer, low address bits dropped
        do_reset(1'b0);
        repeat (3) tick;
        chk("rd_full_addr", imem_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h23;
        tick;
        redirect_valid = 1'b0;
        chk("rd_flush", {31'd0, out_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'h20);
        out_ready = 1'b1;
        tick;
        chk("rd_valid", {31'd0, out_valid}, 32'd1);
        chk("rd_pc", out_pc, 32'h20);
        chk("rd_instr", out_instr, 32'd9);
        tick;
        chk("rd_next", out_pc, 32'h24);

        // Halt with two entries buffered: drain, freeze, resume
        do_reset(1'b0);
        repeat (3) tick;
        halt = 1'b1;
        tick;
        chk("h_addr0", imem_addr, 32'h8);
        out_ready = 1'b1;
        tick;
        chk("h_drain1", out_pc, 32'h4);
        tick;
        chk("h_empty", {31'd0, out_valid}, 32'd0);
        tick;
        chk("h_frozen", imem_addr, 32'h8);
        chk("h_empty2", {31'd0, out_valid}, 32'd0);
        halt = 1'b0;
        tick;
        chk("h_resume_gap", {31'd0, out_valid}, 32'd0);
        tick;
        chk("h_resume_pc", out_pc, 32'h8);
        chk("h_resume_instr", out_instr, 32'd3);

        // Redirect during BOOT is ignored
        do_reset(1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h30;
        tick;
        redirect_valid = 1'b0;
        chk("boot_rd_addr", imem_addr, 32'h0);
        tick;
        chk("boot_rd_pc", out_pc, 32'h0);

`ifdef FETCH_PERF_CNT_EN
        do_reset(1'b1);
        repeat (11) tick;
        chk("cnt10", fetch_count, 32'd10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick;
        redirect_valid = 1'b0;
        chk("cnt_rd", fetch_count, 32'd10);
        repeat (3) tick;
        chk("cnt13", fetch_count, 32'd13);
        rst_n = 1'b0;
        #1;
        chk("cnt_async_clr", fetch_count, 32'd0);
        rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
